// File: rtl/calc_seg_display.sv
// Eight-digit multiplexed seven-segment driver for the calculator result.
// Captures a 32-bit value, scans it as hex digits, and flashes digit 0's dp after each capture.
module calc_seg_display #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned FLASH_CYC = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_valid,
  input  logic [31:0] cal_result,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FLASH_W = $clog2(FLASH_CYC + 1);

  logic [31:0]        shown_q, shown_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [7:0]         seg_q, seg_d;
  logic [7:0]         an_q, an_d;
  logic [2:0]         msd;
  logic [3:0]         nib;
  logic [7:0]         glyph;
  logic               blanked;

  // Hex nibble to active-low segment pattern, dp off.
  function automatic logic [7:0] encode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Highest nonzero nibble; stays 0 for a zero value so digit 0 always shows.
  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (shown_q[4*i +: 4] != 4'h0) msd = 3'(i);
    end
  end

  always_comb begin
    shown_d     = shown_q;
    div_cnt_d   = div_cnt_q;
    idx_d       = idx_q;
    flash_cnt_d = flash_cnt_q;
    seg_d       = 8'hFF;
    an_d        = 8'hFF;
    nib         = shown_q[{idx_q, 2'b00} +: 4];
    glyph       = encode(nib);
    blanked     = blank_lz && (idx_q > msd);

    if (flash_cnt_q != '0) flash_cnt_d = flash_cnt_q - FLASH_W'(1);

    // A new strobe always wins, restarting any running flash.
    if (result_valid) begin
      shown_d     = cal_result;
      flash_cnt_d = FLASH_W'(FLASH_CYC);
    end

    if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 3'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (!blanked) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = {~((idx_q == 3'd0) && (flash_cnt_q != '0)), glyph[6:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown_q     <= '0;
      div_cnt_q   <= '0;
      idx_q       <= '0;
      flash_cnt_q <= '0;
      seg_q       <= 8'hFF;
      an_q        <= 8'hFF;
    end else begin
      shown_q     <= shown_d;
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      flash_cnt_q <= flash_cnt_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
